// File: rtl/ball_bounce_ctrl.sv
// Ball position/direction controller: paces motion with a frame-delay timer and
// runs an erase-then-redraw pass through the 2x2 ball drawer for each move step.
module ball_bounce_ctrl #(
  parameter int X_MAX       = 318,
  parameter int Y_MAX       = 238,
  parameter int X_INIT      = 160,
  parameter int Y_INIT      = 120,
  parameter int WAIT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] ball_color,
  output logic       drawer_start,
  input  logic       drawer_done,
  output logic [8:0] ball_x,
  output logic [7:0] ball_y,
  output logic [2:0] pixel_color
);

  // state   | meaning
  // S_INIT  | first draw of the ball at the reset position
  // S_WAIT  | frame delay between move steps
  // S_ERASE | redraw old position in black
  // S_MOVE  | single cycle: step position, bounce at edges
  // S_DRAW  | draw ball at the new position

  localparam int TW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_CYCLES - 1);
  localparam logic [8:0]    X_LIM      = 9'(X_MAX);
  localparam logic [7:0]    Y_LIM      = 8'(Y_MAX);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_DRAW
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic          start_q, start_d;
  logic [2:0]    pix_q, pix_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;

    unique case (state_q)
      S_INIT: begin
        if (drawer_done) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (run) state_d = S_ERASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ERASE: begin
        if (drawer_done) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (dir_x_q) begin
          if (x_q == X_LIM) begin
            dir_x_d = 1'b0;
            x_d     = x_q - 9'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end else if (x_q == 9'd0) begin
          dir_x_d = 1'b1;
          x_d     = 9'd1;
        end else begin
          x_d = x_q - 9'd1;
        end

        if (dir_y_q) begin
          if (y_q == Y_LIM) begin
            dir_y_d = 1'b0;
            y_d     = y_q - 8'd1;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else if (y_q == 8'd0) begin
          dir_y_d = 1'b1;
          y_d     = 8'd1;
        end else begin
          y_d = y_q - 8'd1;
        end
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (drawer_done) state_d = S_WAIT;
      end
      default: state_d = S_INIT;
    endcase

    // Outputs are registered from the next state so start drops on the edge that sees done.
    start_d = (state_d == S_INIT) || (state_d == S_ERASE) || (state_d == S_DRAW);
    pix_d   = ((state_d == S_INIT) || (state_d == S_DRAW)) ? ball_color : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      timer_q <= '0;
      x_q     <= 9'(X_INIT);
      y_q     <= 8'(Y_INIT);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      start_q <= 1'b0;
      pix_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      start_q <= start_d;
      pix_q   <= pix_d;
    end
  end

  assign drawer_start = start_q;
  assign ball_x       = x_q;
  assign ball_y       = y_q;
  assign pixel_color  = pix_q;

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Bench for ball_bounce_ctrl: randomized drawer latency, run and colour against a
// phase-level reference whose position is a closed-form triangle wave of the step count.
module tb_ball_bounce_ctrl;

  localparam int X_MAX = 318;
  localparam int Y_MAX = 238;
  localparam int X_INIT = 316;
  localparam int Y_INIT = 236;
  localparam int WAIT_CYCLES = 4;

  localparam int PH_INIT = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_ERASE = 2;
  localparam int PH_MOVE = 3;
  localparam int PH_DRAW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [2:0] ball_color;
  logic       drawer_start;
  logic       drawer_done;
  logic [8:0] ball_x;
  logic [7:0] ball_y;
  logic [2:0] pixel_color;

  ball_bounce_ctrl #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .ball_color(ball_color),
    .drawer_start(drawer_start), .drawer_done(drawer_done),
    .ball_x(ball_x), .ball_y(ball_y), .pixel_color(pixel_color)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int ph = PH_INIT;
  int wcnt = 0;
  int steps = 0;
  logic       exp_start = 1'b0;
  logic [2:0] exp_pix = 3'b000;

  // drawer model and observation bookkeeping
  int   dly = 0;
  logic prev_start = 1'b0;
  int   passes = 0;
  int   total_rises = 0;
  int   low_len = 0;
  int   rise_x[8];
  int   rise_y[8];
  int   rise_pix[8];
  int   gap[8];
  int   prev_draw_x = -1;
  int   saw_x0 = 0;
  int   found;
  int   frz_base;

  function automatic int tri_pos(input int start, input int n, input int maxv);
    int u;
    u = (start + n) % (2 * maxv);
    return (u <= maxv) ? u : 2 * maxv - u;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Advances the reference by the clock edge that just passed, using the inputs
  // that were stable across that edge.
  task automatic model_step();
    if (reset) begin
      ph = PH_INIT;
      wcnt = 0;
      steps = 0;
      exp_start = 1'b0;
      exp_pix = 3'b000;
    end else begin
      case (ph)
        PH_INIT:  if (drawer_done) ph = PH_WAIT;
        PH_WAIT: begin
          wcnt++;
          if (wcnt == WAIT_CYCLES) begin
            wcnt = 0;
            if (run) ph = PH_ERASE;
          end
        end
        PH_ERASE: if (drawer_done) ph = PH_MOVE;
        PH_MOVE: begin
          steps++;
          ph = PH_DRAW;
        end
        PH_DRAW:  if (drawer_done) ph = PH_WAIT;
        default:  ph = PH_INIT;
      endcase
      exp_start = (ph == PH_INIT) || (ph == PH_ERASE) || (ph == PH_DRAW);
      exp_pix = ((ph == PH_INIT) || (ph == PH_DRAW)) ? ball_color : 3'b000;
    end
  endtask

  task automatic cycle_step(input bit rnd, input bit tog);
    @(negedge clk);
    model_step();
    chk("drawer_start", {31'd0, drawer_start}, {31'd0, exp_start});
    chk("ball_x", {23'd0, ball_x}, tri_pos(X_INIT, steps, X_MAX));
    chk("ball_y", {24'd0, ball_y}, tri_pos(Y_INIT, steps, Y_MAX));
    chk("pixel_color", {29'd0, pixel_color}, {29'd0, exp_pix});

    if (reset) begin
      passes = 0;
      low_len = 0;
      dly = 0;
      drawer_done = 1'b0;
    end else begin
      if (drawer_start && !prev_start) begin
        passes++;
        total_rises++;
        if (passes < 8) begin
          rise_x[passes] = int'(ball_x);
          rise_y[passes] = int'(ball_y);
          rise_pix[passes] = int'(pixel_color);
          gap[passes] = low_len;
        end
        if (passes >= 3 && (passes % 2) == 1) begin
          if (prev_draw_x == 0) chk("bounce_left_x", {23'd0, ball_x}, 32'd1);
          prev_draw_x = int'(ball_x);
          if (ball_x == 9'd0) saw_x0 = 1;
        end
        low_len = 0;
      end
      if (!drawer_start) low_len++;

      drawer_done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) drawer_done = 1'b1;
      end else if (drawer_start) begin
        dly = rnd ? int'($urandom_range(1, 6)) : 5;
      end else if (rnd && $urandom_range(0, 19) == 0) begin
        drawer_done = 1'b1;
      end
      if (rnd && $urandom_range(0, 9) == 0) ball_color = 3'($urandom);
      if (tog && $urandom_range(0, 199) == 0) run = ~run;
    end
    prev_start = drawer_start;
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b1;
    ball_color = 3'b101;
    drawer_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rise_x[i] = -1;
      rise_y[i] = -1;
      rise_pix[i] = -1;
      gap[i] = -1;
    end

    #1 reset = 1'b1;
    repeat (2) cycle_step(1'b0, 1'b0);
    chk("reset_start", {31'd0, drawer_start}, 32'd0);
    chk("reset_x", {23'd0, ball_x}, 32'd316);
    chk("reset_y", {24'd0, ball_y}, 32'd236);
    chk("reset_pix", {29'd0, pixel_color}, 32'd0);
    reset = 1'b0;

    // deterministic opening: fixed 5-cycle drawer, constant colour, run held high
    repeat (100) cycle_step(1'b0, 1'b0);
    chk("init_x", rise_x[1], 316);
    chk("init_y", rise_y[1], 236);
    chk("init_pix", rise_pix[1], 5);
    chk("wait_len", gap[2], 4);
    chk("erase1_x", rise_x[2], 316);
    chk("erase1_y", rise_y[2], 236);
    chk("erase1_pix", rise_pix[2], 0);
    chk("move_gap", gap[3], 1);
    chk("draw1_x", rise_x[3], 317);
    chk("draw1_y", rise_y[3], 237);
    chk("draw1_pix", rise_pix[3], 5);
    chk("draw2_x", rise_x[5], 318);
    chk("draw2_y", rise_y[5], 238);
    chk("corner_x", rise_x[7], 317);
    chk("corner_y", rise_y[7], 237);

    // freeze: any pass in flight completes, then no further passes start
    run = 1'b0;
    frz_base = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) frz_base = total_rises;
      cycle_step(1'b1, 1'b0);
    end
    chk("freeze_no_pass", total_rises - frz_base, 0);
    run = 1'b1;

    repeat (6000) cycle_step(1'b1, 1'b0);
    chk("reached_x0", saw_x0, 1);
    repeat (3000) cycle_step(1'b1, 1'b1);

    // reset while a DRAW request is outstanding
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      cycle_step(1'b1, 1'b0);
      if (drawer_start && passes >= 3 && (passes % 2) == 1) found = 1;
    end
    chk("found_draw", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_start", {31'd0, drawer_start}, 32'd0);
    chk("midrst_x", {23'd0, ball_x}, 32'd316);
    chk("midrst_y", {24'd0, ball_y}, 32'd236);
    chk("midrst_pix", {29'd0, pixel_color}, 32'd0);
    repeat (2) cycle_step(1'b0, 1'b0);
    reset = 1'b0;
    repeat (60) cycle_step(1'b1, 1'b0);
    chk("reinit_x", rise_x[1], 316);
    chk("reinit_y", rise_y[1], 236);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
